// File: rtl/board_pkg.sv
// Board-level constants shared by the input-conditioning blocks.
// Also holds the per-channel debounce state type and a small max helper.
package board_pkg;

  localparam int unsigned KEYS_W          = 4;
  localparam int unsigned CLK_FREQ_HZ     = 50_000_000;
  localparam int unsigned DEBOUNCE_MS     = 10;
  localparam int unsigned DEBOUNCE_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned REPEAT_DELAY    = 25_000_000;
  localparam int unsigned REPEAT_PERIOD   = 5_000_000;

  typedef enum logic {StStable, StPending} key_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// Single key channel: 2-flop synchronizer, debounce FSM, press/release strobes.
// Auto-repeat of press_o while held is built only when KEY_REPEAT_EN is defined.
module key_debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = board_pkg::DEBOUNCE_CYCLES
`ifdef KEY_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = board_pkg::REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = board_pkg::REPEAT_PERIOD
`endif
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_i,
  output logic key_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]            sync_q;
  logic                  key_sync;
  board_pkg::key_state_e state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  key_q;
  logic                  press_q;
  logic                  release_q;
  logic                  accept;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], key_i};
    end
  end

  assign key_sync = sync_q[1];
  // Last cycle of a full stable run: the new level is taken this edge.
  assign accept   = (state_q == board_pkg::StPending) && (key_sync != key_q) && (cnt_q == CntMax);

`ifdef KEY_REPEAT_EN
  localparam int unsigned     RepW     = $clog2(board_pkg::max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RepW-1:0] RepFirst = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepNext  = RepW'(REPEAT_PERIOD - 1);

  logic [RepW-1:0] rep_cnt_q;
  logic            rep_first_q;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= board_pkg::StStable;
      cnt_q       <= '0;
      key_q       <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state_q)
        board_pkg::StStable: begin
          if (key_sync != key_q) begin
            state_q <= board_pkg::StPending;
            cnt_q   <= CntW'(1);
          end
        end
        board_pkg::StPending: begin
          if (key_sync == key_q) begin
            state_q <= board_pkg::StStable;
            cnt_q   <= '0;
          end else if (accept) begin
            state_q   <= board_pkg::StStable;
            cnt_q     <= '0;
            key_q     <= key_sync;
            press_q   <= key_sync;
            release_q <= ~key_sync;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= board_pkg::StStable;
      endcase
`ifdef KEY_REPEAT_EN
      // A debounced edge in either direction restarts the schedule and suppresses repeats.
      if (!key_q || accept) begin
        rep_cnt_q   <= '0;
        rep_first_q <= 1'b1;
      end else if (rep_cnt_q == (rep_first_q ? RepFirst : RepNext)) begin
        press_q     <= 1'b1;
        rep_cnt_q   <= '0;
        rep_first_q <= 1'b0;
      end else begin
        rep_cnt_q <= rep_cnt_q + RepW'(1);
      end
`endif
    end
  end

  assign key_o     = key_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: one independent key_debounce_ch per key.
// Auto-repeat on held keys is enabled by defining KEY_REPEAT_EN.
module key_conditioner #(
  parameter int unsigned KEYS_W          = board_pkg::KEYS_W,
  parameter int unsigned DEBOUNCE_CYCLES = board_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = board_pkg::REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = board_pkg::REPEAT_PERIOD
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [KEYS_W-1:0] keys_i,
  output logic [KEYS_W-1:0] keys_o,
  output logic [KEYS_W-1:0] press_o,
  output logic [KEYS_W-1:0] release_o
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gen_bad_cfg
    $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2, REPEAT_* must be >= 1");
  end

  for (genvar k = 0; k < KEYS_W; k++) begin : gen_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .key_i     (keys_i[k]),
      .key_o     (keys_o[k]),
      .press_o   (press_o[k]),
      .release_o (release_o[k])
    );
  end

endmodule
